// File: rtl/mc_control_fsm_pkg.sv
// Shared types for the multicycle MIPS control path: datapath mux selects,
// instruction fields, ALU operations, controller states and instruction classes.
package mc_control_fsm_pkg;

    typedef enum logic [1:0] {
        SEL_LOAD_NXT_INSTR = 2'd0,
        SEL_LOAD_JMP_ADDR  = 2'd1,
        SEL_LOAD_JR_ADDR   = 2'd2,
        SEL_LOAD_BR_ADDR   = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        SEL_RESULT            = 2'd0,
        SEL_DLOAD             = 2'd1,
        SEL_NPC               = 2'd2,
        SEL_IMM16_TO_UPPER_32 = 2'd3
    } mem_to_reg_sel_t;

    typedef enum logic {
        SEL_REG_DATA = 1'b0,
        SEL_IMM16    = 1'b1
    } alu_src_sel_t;

    typedef enum logic [1:0] {
        SEL_RD              = 2'd0,
        SEL_RT              = 2'd1,
        SEL_RETURN_REGISTER = 2'd2
    } reg_dest_sel_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD  = 6'h20,
        FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
        FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_NOR, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_RALU, CLS_IALU, CLS_LUI, CLS_LW, CLS_SW,
        CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_JR, CLS_HALT
    } instr_class_t;

    localparam int OPCODE_W = 6;

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational opcode/funct decode into instruction class, ALU controls and
// the write-back mux selects used by the sequencer.
module mc_instr_decode
    import mc_control_fsm_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [5:0]          funct_i,
    output instr_class_t        cls_o,
    output aluop_t              alu_op_o,
    output alu_src_sel_t        alu_src_sel_o,
    output logic                ext_sign_o,
    output reg_dest_sel_t       reg_dest_sel_o,
    output mem_to_reg_sel_t     mem_to_reg_sel_o
);

    always_comb begin
        cls_o            = CLS_NOP;
        alu_op_o         = ALU_ADD;
        alu_src_sel_o    = SEL_REG_DATA;
        ext_sign_o       = 1'b0;
        reg_dest_sel_o   = SEL_RD;
        mem_to_reg_sel_o = SEL_RESULT;
        case (opcode_i)
            OP_RTYPE: begin
                cls_o = CLS_RALU;
                case (funct_i)
                    FN_SLL:          alu_op_o = ALU_SLL;
                    FN_SRL:          alu_op_o = ALU_SRL;
                    FN_JR:           cls_o    = CLS_JR;
                    FN_ADD, FN_ADDU: alu_op_o = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op_o = ALU_SUB;
                    FN_AND:          alu_op_o = ALU_AND;
                    FN_OR:           alu_op_o = ALU_OR;
                    FN_XOR:          alu_op_o = ALU_XOR;
                    FN_NOR:          alu_op_o = ALU_NOR;
                    FN_SLT:          alu_op_o = ALU_SLT;
                    FN_SLTU:         alu_op_o = ALU_SLTU;
                    default:         cls_o    = CLS_NOP;
                endcase
            end
            OP_J:   cls_o = CLS_J;
            OP_JAL: begin
                cls_o            = CLS_JAL;
                reg_dest_sel_o   = SEL_RETURN_REGISTER;
                mem_to_reg_sel_o = SEL_NPC;
            end
            OP_BEQ, OP_BNE: begin
                cls_o      = (opcode_i == OP_BEQ) ? CLS_BEQ : CLS_BNE;
                alu_op_o   = ALU_SUB;
                ext_sign_o = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                cls_o          = CLS_IALU;
                alu_src_sel_o  = SEL_IMM16;
                reg_dest_sel_o = SEL_RT;
                case (opcode_i)
                    OP_SLTI:  alu_op_o = ALU_SLT;
                    OP_SLTIU: alu_op_o = ALU_SLTU;
                    OP_ANDI:  alu_op_o = ALU_AND;
                    OP_ORI:   alu_op_o = ALU_OR;
                    OP_XORI:  alu_op_o = ALU_XOR;
                    default:  alu_op_o = ALU_ADD;
                endcase
                // logical immediates are zero-extended
                ext_sign_o = !(opcode_i == OP_ANDI || opcode_i == OP_ORI || opcode_i == OP_XORI);
            end
            OP_LUI: begin
                cls_o            = CLS_LUI;
                alu_src_sel_o    = SEL_IMM16;
                reg_dest_sel_o   = SEL_RT;
                mem_to_reg_sel_o = SEL_IMM16_TO_UPPER_32;
            end
            OP_LW, OP_SW: begin
                cls_o            = (opcode_i == OP_LW) ? CLS_LW : CLS_SW;
                alu_src_sel_o    = SEL_IMM16;
                ext_sign_o       = 1'b1;
                reg_dest_sel_o   = SEL_RT;
                mem_to_reg_sel_o = SEL_DLOAD;
            end
            OP_HALT: cls_o = CLS_HALT;
            default: cls_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: fetches into an instruction register, then
// walks DECODE/EXEC/MEM/WB driving datapath mux selects and enables.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                ihit,
    input  logic [WORD_W-1:0]   imemload,
    input  logic                dhit,
    input  logic                zero,
    output logic                iREN,
    output logic                dREN,
    output logic                dWEN,
    output logic [WORD_W-1:0]   instr_q,
    output logic                pc_en,
    output logic [1:0]          pc_sel,
    output logic [1:0]          mem_to_reg_sel,
    output logic                alu_src_sel,
    output logic [1:0]          reg_dest_sel,
    output logic                reg_wen,
    output logic                ext_sign,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halt
);

    state_t          state_q, state_d;
    instr_class_t    dec_cls;
    aluop_t          dec_alu_op, alu_op_e;
    alu_src_sel_t    dec_alu_src, alu_src_e;
    reg_dest_sel_t   dec_reg_dest, reg_dest_e;
    mem_to_reg_sel_t dec_mem_to_reg, mem_to_reg_e;
    pc_sel_t         pc_sel_e;
    logic            dec_ext_sign;
    logic            fetch_req;

    mc_instr_decode u_decode (
        .opcode_i         (instr_q[WORD_W-1 -: OPCODE_W]),
        .funct_i          (instr_q[5:0]),
        .cls_o            (dec_cls),
        .alu_op_o         (dec_alu_op),
        .alu_src_sel_o    (dec_alu_src),
        .ext_sign_o       (dec_ext_sign),
        .reg_dest_sel_o   (dec_reg_dest),
        .mem_to_reg_sel_o (dec_mem_to_reg)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && ihit) instr_q <= imemload;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (ihit) state_d = DECODE;
            DECODE: state_d = (dec_cls == CLS_HALT) ? HALT : EXEC;
            EXEC: begin
                case (dec_cls)
                    CLS_LW, CLS_SW:              state_d = MEM;
                    CLS_RALU, CLS_IALU, CLS_LUI: state_d = WB;
                    default:                     state_d = FETCH;
                endcase
            end
            MEM:     if (dhit) state_d = (dec_cls == CLS_LW) ? WB : FETCH;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        fetch_req    = 1'b0;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        pc_en        = 1'b0;
        reg_wen      = 1'b0;
        ext_sign     = 1'b0;
        halt         = 1'b0;
        pc_sel_e     = SEL_LOAD_NXT_INSTR;
        mem_to_reg_e = SEL_RESULT;
        alu_src_e    = SEL_REG_DATA;
        reg_dest_e   = SEL_RD;
        alu_op_e     = ALU_ADD;
        case (state_q)
            FETCH: fetch_req = 1'b1;
            EXEC: begin
                alu_op_e  = dec_alu_op;
                alu_src_e = dec_alu_src;
                ext_sign  = dec_ext_sign;
                case (dec_cls)
                    CLS_J: begin
                        pc_sel_e = SEL_LOAD_JMP_ADDR;
                        pc_en    = 1'b1;
                    end
                    CLS_JAL: begin
                        pc_sel_e     = SEL_LOAD_JMP_ADDR;
                        pc_en        = 1'b1;
                        reg_wen      = 1'b1;
                        reg_dest_e   = dec_reg_dest;
                        mem_to_reg_e = dec_mem_to_reg;
                    end
                    CLS_JR: begin
                        pc_sel_e = SEL_LOAD_JR_ADDR;
                        pc_en    = 1'b1;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        pc_en = 1'b1;
                        if ((dec_cls == CLS_BEQ) == zero) pc_sel_e = SEL_LOAD_BR_ADDR;
                    end
                    CLS_NOP: pc_en = 1'b1;
                    default: ;
                endcase
            end
            MEM: begin
                alu_src_e = SEL_IMM16;
                dREN      = (dec_cls == CLS_LW);
                dWEN      = (dec_cls == CLS_SW);
                pc_en     = dhit && (dec_cls == CLS_SW);
            end
            WB: begin
                reg_wen      = 1'b1;
                pc_en        = 1'b1;
                reg_dest_e   = dec_reg_dest;
                mem_to_reg_e = dec_mem_to_reg;
            end
            HALT:    halt = 1'b1;
            default: ;
        endcase
    end

    // iREN must fall with reset even before the state register settles
    assign iREN           = fetch_req & nRST;
    assign pc_sel         = pc_sel_e;
    assign mem_to_reg_sel = mem_to_reg_e;
    assign alu_src_sel    = alu_src_e;
    assign reg_dest_sel   = reg_dest_e;
    assign alu_op         = alu_op_e;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed and randomized instructions compared
// cycle by cycle against a per-instruction expected output plan.
module tb_mc_control_fsm;
    import mc_control_fsm_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST, ihit, dhit, zero;
    logic [31:0] imemload, instr_q;
    logic        iREN, dREN, dWEN, pc_en, alu_src_sel, reg_wen, ext_sign, halt;
    logic [1:0]  pc_sel, mem_to_reg_sel, reg_dest_sel;
    logic [3:0]  alu_op;

    always #5 CLK = ~CLK;

    mc_control_fsm #(.WORD_W(32), .ALU_OP_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .dhit(dhit),
        .zero(zero), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .instr_q(instr_q),
        .pc_en(pc_en), .pc_sel(pc_sel), .mem_to_reg_sel(mem_to_reg_sel),
        .alu_src_sel(alu_src_sel), .reg_dest_sel(reg_dest_sel), .reg_wen(reg_wen),
        .ext_sign(ext_sign), .alu_op(alu_op), .halt(halt)
    );

    typedef struct packed {
        logic       iren, dren, dwen, pc_en;
        logic [1:0] pc_sel, m2r;
        logic       asrc;
        logic [1:0] rdest;
        logic       reg_wen;
        logic [3:0] alu_op;
        logic       ext, halt;
    } outs_t;

    localparam int P_FETCH = 0, P_DEC = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
    localparam int K_NOP = 0, K_R = 1, K_I = 2, K_LUI = 3, K_LW = 4, K_SW = 5,
                   K_BR = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_HALT = 10;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_word;
    outs_t       exp_q[$];
    int          ph_q[$];

    function automatic outs_t idle_outs();
        outs_t o = '0;
        o.pc_sel = SEL_LOAD_NXT_INSTR;
        o.m2r    = SEL_RESULT;
        o.asrc   = SEL_REG_DATA;
        o.rdest  = SEL_RD;
        o.alu_op = ALU_ADD;
        return o;
    endfunction

    function automatic outs_t got_outs();
        outs_t o;
        o = '{iREN, dREN, dWEN, pc_en, pc_sel, mem_to_reg_sel, alu_src_sel,
              reg_dest_sel, reg_wen, alu_op, ext_sign, halt};
        return o;
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, expv);
        end
    endtask

    // Expected outputs of one instruction, cycle by cycle, from the sequencing rules.
    task automatic plan(input logic [31:0] w, input int ihw, input int dhw, input logic z);
        logic [5:0] op, fn;
        outs_t      o, e;
        int         kind;
        logic [3:0] a;
        logic       imm, ext;
        op = w[31:26];
        fn = w[5:0];
        exp_q.delete();
        ph_q.delete();
        o = idle_outs();
        for (int k = 0; k <= ihw; k++) begin
            e = o; e.iren = 1'b1;
            exp_q.push_back(e); ph_q.push_back(P_FETCH);
        end
        exp_q.push_back(o); ph_q.push_back(P_DEC);
        kind = K_NOP; a = ALU_ADD; imm = 1'b0; ext = 1'b0;
        case (op)
            6'h00: begin
                kind = K_R;
                case (fn)
                    6'h00: a = ALU_SLL;
                    6'h02: a = ALU_SRL;
                    6'h08: kind = K_JR;
                    6'h20, 6'h21: a = ALU_ADD;
                    6'h22, 6'h23: a = ALU_SUB;
                    6'h24: a = ALU_AND;
                    6'h25: a = ALU_OR;
                    6'h26: a = ALU_XOR;
                    6'h27: a = ALU_NOR;
                    6'h2A: a = ALU_SLT;
                    6'h2B: a = ALU_SLTU;
                    default: kind = K_NOP;
                endcase
            end
            6'h02: kind = K_J;
            6'h03: kind = K_JAL;
            6'h04, 6'h05: begin kind = K_BR; a = ALU_SUB; ext = 1'b1; end
            6'h08, 6'h09: begin kind = K_I; imm = 1'b1; ext = 1'b1; end
            6'h0A: begin kind = K_I; imm = 1'b1; ext = 1'b1; a = ALU_SLT; end
            6'h0B: begin kind = K_I; imm = 1'b1; ext = 1'b1; a = ALU_SLTU; end
            6'h0C: begin kind = K_I; imm = 1'b1; a = ALU_AND; end
            6'h0D: begin kind = K_I; imm = 1'b1; a = ALU_OR; end
            6'h0E: begin kind = K_I; imm = 1'b1; a = ALU_XOR; end
            6'h0F: begin kind = K_LUI; imm = 1'b1; end
            6'h23: begin kind = K_LW; imm = 1'b1; ext = 1'b1; end
            6'h2B: begin kind = K_SW; imm = 1'b1; ext = 1'b1; end
            6'h3F: kind = K_HALT;
            default: kind = K_NOP;
        endcase
        if (kind == K_HALT) begin
            for (int k = 0; k < 20; k++) begin
                e = o; e.halt = 1'b1;
                exp_q.push_back(e); ph_q.push_back(P_HALT);
            end
            return;
        end
        e = o; e.alu_op = a; e.asrc = imm; e.ext = ext;
        case (kind)
            K_J:   begin e.pc_en = 1'b1; e.pc_sel = SEL_LOAD_JMP_ADDR; end
            K_JAL: begin
                e.pc_en = 1'b1; e.pc_sel = SEL_LOAD_JMP_ADDR; e.reg_wen = 1'b1;
                e.rdest = SEL_RETURN_REGISTER; e.m2r = SEL_NPC;
            end
            K_JR:  begin e.pc_en = 1'b1; e.pc_sel = SEL_LOAD_JR_ADDR; end
            K_BR:  begin
                e.pc_en  = 1'b1;
                e.pc_sel = ((op == 6'h04 && z) || (op == 6'h05 && !z)) ? SEL_LOAD_BR_ADDR : SEL_LOAD_NXT_INSTR;
            end
            K_NOP: e.pc_en = 1'b1;
            default: ;
        endcase
        exp_q.push_back(e); ph_q.push_back(P_EX);
        if (kind == K_LW || kind == K_SW) begin
            for (int k = 0; k <= dhw; k++) begin
                e = o; e.asrc = SEL_IMM16;
                e.dren  = (kind == K_LW);
                e.dwen  = (kind == K_SW);
                e.pc_en = (kind == K_SW) && (k == dhw);
                exp_q.push_back(e); ph_q.push_back(P_MEM);
            end
        end
        if (kind == K_R || kind == K_I || kind == K_LUI || kind == K_LW) begin
            e = o; e.reg_wen = 1'b1; e.pc_en = 1'b1;
            e.rdest = (kind == K_R) ? SEL_RD : SEL_RT;
            e.m2r   = (kind == K_LW) ? SEL_DLOAD : (kind == K_LUI) ? SEL_IMM16_TO_UPPER_32 : SEL_RESULT;
            exp_q.push_back(e); ph_q.push_back(P_WB);
        end
    endtask

    task automatic do_reset(input string tag);
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0;
        #2;
        chk({tag, "_outs"}, 0, 64'(got_outs()), 64'(idle_outs()));
        chk({tag, "_instr"}, 0, 64'(instr_q), 64'd0);
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;
        prev_word = '0;
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after the last cycle.
    task automatic run(input string tag, input logic [31:0] w, input int ihw, input int dhw,
                       input logic z, input int abort_at);
        plan(w, ihw, dhw, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            int          ph = ph_q[i];
            logic [31:0] r  = $urandom;
            ihit     = (ph == P_FETCH) ? (i == ihw) : r[0];
            imemload = (ph == P_FETCH && i == ihw) ? w : $urandom;
            dhit     = (ph == P_MEM) ? (i == ihw + 3 + dhw) : r[1];
            zero     = (ph == P_EX) ? z : r[2];
            if (i == abort_at) begin
                #2 nRST = 1'b0;
                #1;
                chk({tag, "_rst_now"}, i, 64'(got_outs()), 64'(idle_outs()));
                chk({tag, "_rst_instr"}, i, 64'(instr_q), 64'd0);
                @(posedge CLK); #1;
                chk({tag, "_rst_hold"}, i, 64'(got_outs()), 64'(idle_outs()));
                ihit = 1'b0; dhit = 1'b0;
                @(negedge CLK) nRST = 1'b1;
                @(posedge CLK); #1;
                prev_word = '0;
                return;
            end
            @(negedge CLK);
            chk({tag, "_outs"}, i, 64'(got_outs()), 64'(exp_q[i]));
            chk({tag, "_instr"}, i, 64'(instr_q), 64'((i <= ihw) ? prev_word : w));
            @(posedge CLK); #1;
        end
        prev_word = w;
    endtask

    logic [5:0] ops[16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h11};
    logic [5:0] fns[14] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3C};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w, r;
        nRST = 1'b1; ihit = 1'b0; dhit = 1'b0; zero = 1'b0; imemload = '0;
        prev_word = '0;
        #1;
        do_reset("por");
        run("addu", 32'h00221821, 0, 0, 1'b0, -1);
        run("lw_dhit3", 32'h8C220004, 0, 2, 1'b0, -1);
        run("beq_taken", 32'h10220003, 0, 0, 1'b1, -1);
        run("beq_not", 32'h10220003, 0, 0, 1'b0, -1);
        run("bne_taken", 32'h14220003, 1, 0, 1'b0, -1);
        run("jal", 32'h0C000010, 0, 0, 1'b0, -1);
        run("jr", 32'h03E00008, 2, 0, 1'b0, -1);
        run("lui", 32'h3C011234, 0, 0, 1'b0, -1);
        run("sw", 32'hAC220008, 0, 0, 1'b0, -1);
        run("sw_rst", 32'hAC220008, 1, 4, 1'b0, 5);
        run("after_rst", 32'h00221821, 0, 0, 1'b0, -1);
        for (int n = 0; n < 80; n++) begin
            r = $urandom;
            w = {ops[$urandom_range(0, 15)], r[25:0]};
            if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 13)];
            run("rand", w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end
        run("halt", 32'hFFFFFFFF, 5, 0, 1'b0, -1);
        do_reset("post_halt");
        run("addu_again", 32'h00221821, 0, 0, 1'b0, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
